// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with single-outstanding memory request
//
// Ports:
//   CLK                clock, all state updates on rising edge
//   RST_N              synchronous active-low reset
//   STALL_FETCH_STAGE  hold decode-facing outputs
//   CLEAR_FETCH_STAGE  replace decode-facing outputs with a bubble
//   BRANCH_TAKEN       redirect fetch PC to BRANCH_TARGET (word aligned)
//   BRANCH_TARGET      redirect address
//   IMEM_REQ_VALID     request valid toward instruction memory
//   IMEM_REQ_READY     memory accepts the request
//   IMEM_ADDR          request address
//   IMEM_RESP_VALID    response data valid
//   IMEM_RESP_DATA     fetched instruction word
//   INSTRUCTION        registered instruction to decode
//   PC_OUT             registered PC of INSTRUCTION
//   INSTRUCTION_VALID  INSTRUCTION is a fetched word rather than a bubble
module fetch_stage #(
    parameter logic [31:0] RESET_PC        = 32'h00000000,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h00000013,
    parameter logic        HIGH            = 1'b1,
    parameter logic        LOW             = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL_FETCH_STAGE,
    input  logic        CLEAR_FETCH_STAGE,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_REQ_VALID,
    input  logic        IMEM_REQ_READY,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_RESP_VALID,
    input  logic [31:0] IMEM_RESP_DATA,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC_OUT,
    output logic        INSTRUCTION_VALID
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state, state_d;
    logic [31:0] fetch_pc, fetch_pc_d;
    logic [31:0] req_pc, req_pc_d;
    logic        drop, drop_d;
    logic [31:0] hold_data, hold_data_d;
    logic [31:0] hold_pc, hold_pc_d;

    logic        deliver;
    logic [31:0] deliver_data;
    logic [31:0] deliver_pc;
    logic [31:0] branch_pc;

    assign branch_pc      = {BRANCH_TARGET[31:2], 2'b00};
    assign IMEM_REQ_VALID = (state == REQ) ? HIGH : LOW;
    assign IMEM_ADDR      = fetch_pc;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            req_pc    <= 32'h0;
            drop      <= LOW;
            hold_data <= 32'h0;
            hold_pc   <= 32'h0;
        end else begin
            state     <= state_d;
            fetch_pc  <= fetch_pc_d;
            req_pc    <= req_pc_d;
            drop      <= drop_d;
            hold_data <= hold_data_d;
            hold_pc   <= hold_pc_d;
        end
    end

    always_comb begin
        state_d      = state;
        fetch_pc_d   = fetch_pc;
        req_pc_d     = req_pc;
        drop_d       = drop;
        hold_data_d  = hold_data;
        hold_pc_d    = hold_pc;
        deliver      = LOW;
        deliver_data = hold_data;
        deliver_pc   = hold_pc;

        case (state)
            IDLE: begin
                state_d = REQ;
                if (BRANCH_TAKEN) fetch_pc_d = branch_pc;
            end
            REQ: begin
                if (IMEM_REQ_READY) begin
                    req_pc_d = fetch_pc;
                    state_d  = WAIT;
                    // The accepted request is for the old path; its response must be thrown away.
                    if (BRANCH_TAKEN) drop_d = HIGH;
                end
                if (BRANCH_TAKEN) fetch_pc_d = branch_pc;
            end
            WAIT: begin
                if (IMEM_RESP_VALID) begin
                    if (BRANCH_TAKEN || drop) begin
                        drop_d  = LOW;
                        state_d = REQ;
                        if (BRANCH_TAKEN) fetch_pc_d = branch_pc;
                    end else if (STALL_FETCH_STAGE) begin
                        hold_data_d = IMEM_RESP_DATA;
                        hold_pc_d   = req_pc;
                        state_d     = HOLD;
                    end else begin
                        deliver      = HIGH;
                        deliver_data = IMEM_RESP_DATA;
                        deliver_pc   = req_pc;
                        fetch_pc_d   = req_pc + 32'd4;
                        state_d      = REQ;
                    end
                end else if (BRANCH_TAKEN) begin
                    drop_d     = HIGH;
                    fetch_pc_d = branch_pc;
                end
            end
            HOLD: begin
                if (BRANCH_TAKEN) begin
                    hold_data_d = 32'h0;
                    hold_pc_d   = 32'h0;
                    fetch_pc_d  = branch_pc;
                    state_d     = REQ;
                end else if (!STALL_FETCH_STAGE) begin
                    deliver    = HIGH;
                    fetch_pc_d = hold_pc + 32'd4;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear wins over stall and over a same-cycle delivery; a stall freezes the
    // decode side while the memory side keeps running.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            INSTRUCTION       <= NOP_INSTRUCTION;
            PC_OUT            <= 32'h0;
            INSTRUCTION_VALID <= LOW;
        end else if (CLEAR_FETCH_STAGE) begin
            INSTRUCTION       <= NOP_INSTRUCTION;
            PC_OUT            <= 32'h0;
            INSTRUCTION_VALID <= LOW;
        end else if (!STALL_FETCH_STAGE) begin
            if (deliver) begin
                INSTRUCTION       <= deliver_data;
                PC_OUT            <= deliver_pc;
                INSTRUCTION_VALID <= HIGH;
            end else begin
                INSTRUCTION       <= NOP_INSTRUCTION;
                INSTRUCTION_VALID <= LOW;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        STALL_FETCH_STAGE;
    logic        CLEAR_FETCH_STAGE;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        IMEM_REQ_VALID;
    logic        IMEM_REQ_READY;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RESP_VALID;
    logic [31:0] IMEM_RESP_DATA;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC_OUT;
    logic        INSTRUCTION_VALID;

    int checks = 0;
    int passed = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    always #5 CLK = ~CLK;

    fetch_stage dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .STALL_FETCH_STAGE (STALL_FETCH_STAGE),
        .CLEAR_FETCH_STAGE (CLEAR_FETCH_STAGE),
        .BRANCH_TAKEN      (BRANCH_TAKEN),
        .BRANCH_TARGET     (BRANCH_TARGET),
        .IMEM_REQ_VALID    (IMEM_REQ_VALID),
        .IMEM_REQ_READY    (IMEM_REQ_READY),
        .IMEM_ADDR         (IMEM_ADDR),
        .IMEM_RESP_VALID   (IMEM_RESP_VALID),
        .IMEM_RESP_DATA    (IMEM_RESP_DATA),
        .INSTRUCTION       (INSTRUCTION),
        .PC_OUT            (PC_OUT),
        .INSTRUCTION_VALID (INSTRUCTION_VALID)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ins, input logic [31:0] pc, input logic v);
        chk({tag, ".instr"}, INSTRUCTION, ins);
        chk({tag, ".pc"}, PC_OUT, pc);
        chk({tag, ".valid"}, {31'b0, INSTRUCTION_VALID}, {31'b0, v});
    endtask

    initial begin
        RST_N = 1'b0;
        STALL_FETCH_STAGE = 1'b0;
        CLEAR_FETCH_STAGE = 1'b0;
        BRANCH_TAKEN = 1'b0;
        BRANCH_TARGET = 32'h0;
        IMEM_REQ_READY = 1'b0;
        IMEM_RESP_VALID = 1'b0;
        IMEM_RESP_DATA = 32'h0;

        // Reset state
        step();
        step();
        chk_out("reset", NOP, 32'h0, 1'b0);
        chk("reset.req_valid", {31'b0, IMEM_REQ_VALID}, 32'h0);

        // Basic fetch: IDLE one cycle, then request at address 0
        RST_N = 1'b1;
        chk("idle.req_valid", {31'b0, IMEM_REQ_VALID}, 32'h0);
        step();
        chk("req0.req_valid", {31'b0, IMEM_REQ_VALID}, 32'h1);
        chk("req0.addr", IMEM_ADDR, 32'h0);
        IMEM_REQ_READY = 1'b1;
        step();
        chk("wait0.req_valid", {31'b0, IMEM_REQ_VALID}, 32'h0);
        IMEM_REQ_READY = 1'b0;
        IMEM_RESP_VALID = 1'b1;
        IMEM_RESP_DATA = 32'h00500093;
        step();
        chk_out("deliver0", 32'h00500093, 32'h0, 1'b1);
        chk("deliver0.next_addr", IMEM_ADDR, 32'h4);
        chk("deliver0.req_valid", {31'b0, IMEM_REQ_VALID}, 32'h1);
        IMEM_RESP_VALID = 1'b0;

        // READY low for three cycles: request held stable
        for (int i = 0; i < 3; i++) begin
            step();
            chk("backpressure.req_valid", {31'b0, IMEM_REQ_VALID}, 32'h1);
            chk("backpressure.addr", IMEM_ADDR, 32'h4);
        end
        chk_out("bubble", NOP, 32'h0, 1'b0);
        IMEM_REQ_READY = 1'b1;
        step();
        IMEM_REQ_READY = 1'b0;
        chk("single_accept.req_valid", {31'b0, IMEM_REQ_VALID}, 32'h0);

        // Stall when response arrives, released four cycles later
        STALL_FETCH_STAGE = 1'b1;
        IMEM_RESP_VALID = 1'b1;
        IMEM_RESP_DATA = 32'h00A00113;
        step();
        IMEM_RESP_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold.req_valid", {31'b0, IMEM_REQ_VALID}, 32'h0);
            chk_out("hold", NOP, 32'h0, 1'b0);
            step();
        end
        STALL_FETCH_STAGE = 1'b0;
        step();
        chk_out("release", 32'h00A00113, 32'h4, 1'b1);
        chk("release.next_addr", IMEM_ADDR, 32'h8);
        STALL_FETCH_STAGE = 1'b1;
        step();
        chk_out("stall_valid_held", 32'h00A00113, 32'h4, 1'b1);
        STALL_FETCH_STAGE = 1'b0;

        // Branch in WAIT before the response: response discarded
        IMEM_REQ_READY = 1'b1;
        step();
        IMEM_REQ_READY = 1'b0;
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'h00000102;
        step();
        BRANCH_TAKEN = 1'b0;
        IMEM_RESP_VALID = 1'b1;
        IMEM_RESP_DATA = 32'hDEADBEEF;
        step();
        IMEM_RESP_VALID = 1'b0;
        chk_out("drop", NOP, 32'h4, 1'b0);
        chk("drop.addr", IMEM_ADDR, 32'h00000100);
        chk("drop.req_valid", {31'b0, IMEM_REQ_VALID}, 32'h1);

        // Clear together with stall on a pending response
        IMEM_REQ_READY = 1'b1;
        step();
        IMEM_REQ_READY = 1'b0;
        IMEM_RESP_VALID = 1'b1;
        IMEM_RESP_DATA = 32'h11111111;
        STALL_FETCH_STAGE = 1'b1;
        CLEAR_FETCH_STAGE = 1'b1;
        step();
        chk_out("clear", NOP, 32'h0, 1'b0);
        IMEM_RESP_VALID = 1'b0;
        STALL_FETCH_STAGE = 1'b0;
        CLEAR_FETCH_STAGE = 1'b0;
        step();
        chk_out("after_clear", 32'h11111111, 32'h00000100, 1'b1);
        chk("after_clear.addr", IMEM_ADDR, 32'h00000104);

        // Unaligned branch target to top of memory, PC wraps
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'hFFFFFFFF;
        step();
        BRANCH_TAKEN = 1'b0;
        chk("wrap.addr", IMEM_ADDR, 32'hFFFFFFFC);
        IMEM_REQ_READY = 1'b1;
        step();
        IMEM_REQ_READY = 1'b0;
        IMEM_RESP_VALID = 1'b1;
        IMEM_RESP_DATA = 32'h22222222;
        step();
        IMEM_RESP_VALID = 1'b0;
        chk_out("wrap", 32'h22222222, 32'hFFFFFFFC, 1'b1);
        chk("wrap.next_addr", IMEM_ADDR, 32'h0);

        // Reset mid-transaction; late response must be ignored
        IMEM_REQ_READY = 1'b1;
        step();
        IMEM_REQ_READY = 1'b0;
        RST_N = 1'b0;
        step();
        chk_out("midreset", NOP, 32'h0, 1'b0);
        RST_N = 1'b1;
        IMEM_RESP_VALID = 1'b1;
        IMEM_RESP_DATA = 32'h33333333;
        step();
        chk_out("late_resp", NOP, 32'h0, 1'b0);
        step();
        IMEM_RESP_VALID = 1'b0;
        chk_out("late_resp2", NOP, 32'h0, 1'b0);
        chk("late_resp.req_valid", {31'b0, IMEM_REQ_VALID}, 32'h1);
        chk("late_resp.addr", IMEM_ADDR, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h00000000, fetch address loaded on reset.
REQ-002 Parameter NOP_INSTRUCTION, 32'h00000013 (addi x0,x0,0), bubble value driven to decode.
REQ-003 Parameter HIGH / LOW, 1'b1 / 1'b0, logic level constants.
REQ-004 CLK  input  1  single clock; all state updates on posedge.
REQ-005 RST_N  input  1  reset, synchronous, active-low.
REQ-006 STALL_FETCH_STAGE  input  1  hold decode-facing outputs.
REQ-007 CLEAR_FETCH_STAGE  input  1  replace decode-facing outputs with bubble.
REQ-008 BRANCH_TAKEN  input  1  redirect fetch PC this cycle.
REQ-009 BRANCH_TARGET  input  32  redirect address.
REQ-010 IMEM_REQ_VALID  output  1  instruction memory request valid.
REQ-011 IMEM_REQ_READY  input  1  memory accepts request.
REQ-012 IMEM_ADDR  output  32  request address, word aligned.
REQ-013 IMEM_RESP_VALID  input  1  response data valid.
REQ-014 IMEM_RESP_DATA  input  32  fetched instruction word.
REQ-015 INSTRUCTION  output  32  registered instruction to decode stage.
REQ-016 PC_OUT  output  32  registered PC of INSTRUCTION.
REQ-017 INSTRUCTION_VALID  output  1  INSTRUCTION is a real fetched word, not a bubble.

Function
REQ-018 FSM states IDLE, REQ, WAIT, HOLD; IDLE lasts exactly one cycle after reset release, then REQ.
REQ-019 REQ: IMEM_REQ_VALID=1, IMEM_ADDR=fetch PC; address stable until VALID&READY; accept -> latch req_pc, go WAIT.
REQ-020 One outstanding request max; IMEM_REQ_VALID=0 in IDLE, WAIT, HOLD.
REQ-021 Responses arrive no earlier than the cycle after acceptance; RESP_VALID outside WAIT is ignored.
REQ-022 WAIT + RESP_VALID, no drop, STALL low: next cycle INSTRUCTION=RESP_DATA, PC_OUT=req_pc, VALID=1; fetch PC<=req_pc+4; go REQ.
REQ-023 WAIT + RESP_VALID, no drop, STALL high: capture data/req_pc in hold buffer, outputs unchanged, go HOLD.
REQ-024 HOLD: on first cycle STALL low, load outputs from hold buffer (VALID=1), fetch PC<=buffered pc+4, go REQ.
REQ-025 Any non-stalled, non-cleared cycle with no instruction delivered: INSTRUCTION=NOP_INSTRUCTION, PC_OUT unchanged, VALID=0.
REQ-026 STALL high: INSTRUCTION, PC_OUT, INSTRUCTION_VALID hold; FSM/memory side continues per REQ-023.
REQ-027 CLEAR high: next cycle INSTRUCTION=NOP_INSTRUCTION, PC_OUT=0, VALID=0; CLEAR overrides STALL and any delivery that cycle (delivered word lost).
REQ-028 BRANCH_TAKEN: fetch PC<={BRANCH_TARGET[31:2],2'b00}; overrides STALL; does not alter decode-facing outputs.
REQ-029 Redirect in REQ without accept: next cycle IMEM_ADDR=target; with same-cycle accept: set drop flag, go WAIT.
REQ-030 Redirect in WAIT without response: set drop flag; with same-cycle response: discard response, go REQ.
REQ-031 Redirect in HOLD: discard hold buffer, go REQ.
REQ-032 WAIT + RESP_VALID with drop flag: discard, clear flag, go REQ, outputs per REQ-025/026.
REQ-033 PC+4 is 32-bit modulo: 32'hFFFFFFFC -> 32'h00000000.
REQ-034 Best-case latency: accept cycle N, response N+1, INSTRUCTION valid N+2; peak throughput one instruction per two cycles.

Reset
REQ-035 RST_N low at posedge: state IDLE, fetch PC=RESET_PC, drop flag 0, hold buffer cleared, IMEM_REQ_VALID=0, INSTRUCTION=NOP_INSTRUCTION, PC_OUT=0, INSTRUCTION_VALID=0.
REQ-036 Reset overrides all inputs, including mid-transaction; an in-flight response arriving after reset release is ignored (state not WAIT).

Verification
REQ-037 Reset release, READY=1, response 1 cycle after accept, data 32'h00500093 -> IMEM_ADDR=0 at cycle 2, INSTRUCTION=32'h00500093, PC_OUT=0, VALID=1 two cycles after accept; next IMEM_ADDR=4.
REQ-038 READY low 3 cycles in REQ -> IMEM_REQ_VALID=1 and IMEM_ADDR constant throughout; single accept.
REQ-039 STALL high when response 32'h00A00113 arrives, released 4 cycles later -> outputs held, HOLD entered, no new request; after release INSTRUCTION=32'h00A00113, VALID=1.
REQ-040 BRANCH_TAKEN, target 32'h00000102, in WAIT before response -> response discarded, next IMEM_ADDR=32'h00000100, no bubble marked VALID.
REQ-041 CLEAR and STALL together with pending delivery -> INSTRUCTION=32'h00000013, PC_OUT=0, VALID=0.
REQ-042 Fetch PC 32'hFFFFFFFC delivered -> next IMEM_ADDR=32'h00000000.
